axis_ifft_frame_packer: RTL and testbench

Upstream neighbour of the 8-point IFFT core. It accepts one complex frequency-domain sample per AXI4-Stream beat (32-bit real, 32-bit imag), gathers eight of them into a frame, and presents that frame as one 512-bit beat in the exact slot layout the IFFT core expects. It enforces frame boundaries using `s_axis_tlast`, zero-pads short frames and flags framing errors. It sustains one input sample per cycle under continuous downstream readiness.

---
 rtl/ifft_axis_pkg.sv | 18 +
 rtl/axis_frame_out_reg.sv | 31 +++
 rtl/axis_ifft_frame_packer.sv | 123 ++++++++++++
 tb/tb_axis_ifft_frame_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_axis_pkg.sv
// rtl/ifft_axis_pkg.sv - shared constants, slot layout and FSM states for the 8-point IFFT stream path
package ifft_axis_pkg;
  localparam int N_POINTS = 8;
  localparam int SAMPLE_W = 32;
  localparam int SLOT_W   = 3;
  localparam int BEAT_W   = 2 * SAMPLE_W;
  localparam int FRAME_W  = N_POINTS * BEAT_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bit offset of slot k inside a frame; the IFFT core relies on this exact layout.
  function automatic int slot_offset(input logic [SLOT_W-1:0] k);
    return BEAT_W * int'(k);
  endfunction
endpackage

// File: rtl/axis_frame_out_reg.sv
// rtl/axis_frame_out_reg.sv - single-entry frame holding register with valid/ready and load strobe
module axis_frame_out_reg #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  // A load takes priority so a frame can leave and the next arrive on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/axis_ifft_frame_packer.sv
// rtl/axis_ifft_frame_packer.sv - packs eight complex samples into one 512-bit IFFT input beat
module axis_ifft_frame_packer
  import ifft_axis_pkg::*;
#(
  parameter int C_SAMPLE_WIDTH     = 32,
  parameter int C_AXIS_TDATA_WIDTH = 2 * C_SAMPLE_WIDTH,
  parameter int C_AXIS_TOUT_WIDTH  = 8 * C_AXIS_TDATA_WIDTH,
  parameter int C_ERRCNT_WIDTH     = 16
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          err_short,
  output logic                          err_long,
  output logic [C_ERRCNT_WIDTH-1:0]     err_cnt
);
  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [SLOT_W-1:0]              r_slot;
  logic [C_AXIS_TOUT_WIDTH-1:0]   r_asm;
  logic [C_AXIS_TOUT_WIDTH-1:0]   w_frame;
  logic                           w_accept;
  logic                           w_last_slot;
  logic                           w_close;
  logic                           w_free;
  logic                           w_load;
  logic                           w_err_short;
  logic                           w_err_long;
  logic                           r_err_short;
  logic                           r_err_long;
  logic [C_ERRCNT_WIDTH-1:0]      r_err_cnt;

  assign s_axis_tready = (r_state == FILL);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_last_slot   = (r_slot == SLOT_W'(N_POINTS - 1));
  assign w_close       = w_accept & (s_axis_tlast | w_last_slot);
  assign w_free        = ~m_axis_tvalid | m_axis_tready;
  assign w_err_short   = w_close & s_axis_tlast & ~w_last_slot;
  assign w_err_long    = w_close & w_last_slot & ~s_axis_tlast;

  // The accepted sample is merged here so a closing beat can go straight to the output.
  always_comb begin
    w_frame = r_asm;
    if (w_accept) begin
      w_frame[slot_offset(r_slot) +: C_AXIS_TDATA_WIDTH] = s_axis_tdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_close) begin
          if (w_free) w_load = 1'b1;
          else        w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state <= FILL;
      r_slot  <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_asm  <= '0;
        r_slot <= '0;
      end else if (w_accept) begin
        r_asm  <= w_frame;
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_short <= w_err_short;
      r_err_long  <= w_err_long;
      if ((w_err_short | w_err_long) && (r_err_cnt != {C_ERRCNT_WIDTH{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  axis_frame_out_reg #(
    .W (C_AXIS_TOUT_WIDTH)
  ) u_out_reg (
    .clk     (s_axis_aclk),
    .rst     (s_axis_areset),
    .i_load  (w_load),
    .i_data  (w_frame),
    .i_ready (m_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (m_axis_tdata)
  );

  assign m_axis_tlast = m_axis_tvalid;
  assign err_short    = r_err_short;
  assign err_long     = r_err_long;
  assign err_cnt      = r_err_cnt;
endmodule

// File: tb/tb_axis_ifft_frame_packer.sv
// tb/tb_axis_ifft_frame_packer.sv - directed self-checking bench for axis_ifft_frame_packer
module tb_axis_ifft_frame_packer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  s_tdata;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [511:0] m_tdata;
  logic         m_tlast;
  logic         e_short;
  logic         e_long;
  logic [15:0]  e_cnt;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [511:0] got_q[$];

  always #5 clk = ~clk;

  axis_ifft_frame_packer dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .err_short     (e_short),
    .err_long      (e_long),
    .err_cnt       (e_cnt)
  );

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) got_q.push_back(m_tdata);
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic last, output int cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("accept", acc, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    check_eq({tag, "_m_tdata"}, m_tdata, '0);
    check_eq({tag, "_m_tlast"}, m_tlast, 1'b0);
    check_eq({tag, "_err_short"}, e_short, 1'b0);
    check_eq({tag, "_err_long"}, e_long, 1'b0);
    check_eq({tag, "_err_cnt"}, e_cnt, 16'd0);
    check_eq({tag, "_s_tready"}, s_tready, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [511:0] exp);
    check_eq({tag, "_present"}, (got_q.size() > 0), 1'b1);
    if (got_q.size() > 0) check_eq(tag, got_q.pop_front(), exp);
  endtask

  initial begin
    logic [511:0] exp_a;
    logic [511:0] exp_b;
    logic [63:0]  b;
    logic [31:0]  re;
    logic [31:0]  im;
    int           cyc;
    int           total;

    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Full frame: real = k*0x01000001, imag = -k
    exp_a = '0;
    for (int k = 0; k < 8; k++) begin
      re = 32'(k) * 32'h0100_0001;
      im = 32'(-k);
      b  = {re, im};
      exp_a[64*k +: 64] = b;
      send(b, (k == 7), cyc);
    end
    @(negedge clk);
    check_eq("t1_tvalid", m_tvalid, 1'b1);
    check_eq("t1_tlast", m_tlast, 1'b1);
    check_eq("t1_err_short", e_short, 1'b0);
    check_eq("t1_err_long", e_long, 1'b0);
    @(posedge clk);
    #1;
    check_frame("t1_frame", exp_a);
    check_eq("t1_slot5", exp_a[383:320], 64'h0500_0005_FFFF_FFFB);

    // Short frame: tlast on beat 4
    exp_a = '0;
    for (int k = 0; k < 5; k++) begin
      b = {32'hA000_0000 + 32'(k), 32'h0000_0A00 + 32'(k)};
      exp_a[64*k +: 64] = b;
      send(b, (k == 4), cyc);
    end
    @(negedge clk);
    check_eq("t2_err_short", e_short, 1'b1);
    check_eq("t2_err_long", e_long, 1'b0);
    @(negedge clk);
    check_eq("t2_err_short_clear", e_short, 1'b0);
    check_eq("t2_err_cnt", e_cnt, 16'd1);
    @(posedge clk);
    #1;
    check_frame("t2_frame", exp_a);

    // Long frame: ten beats without tlast, then a closing beat at slot 2
    exp_a = '0;
    exp_b = '0;
    for (int k = 0; k < 11; k++) begin
      b = {32'hB000_0000 + 32'(k), 32'hFFFF_0000 + 32'(k)};
      if (k < 8) exp_a[64*k +: 64] = b;
      else       exp_b[64*(k-8) +: 64] = b;
      send(b, (k == 10), cyc);
      if (k == 7) begin
        @(negedge clk);
        check_eq("t3_err_long", e_long, 1'b1);
        check_eq("t3_err_cnt_long", e_cnt, 16'd2);
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check_eq("t3_err_short", e_short, 1'b1);
    check_eq("t3_err_cnt", e_cnt, 16'd3);
    @(posedge clk);
    #1;
    check_frame("t3_frame_a", exp_a);
    check_frame("t3_frame_b", exp_b);

    // Backpressure across two frames
    m_tready = 1'b0;
    exp_a = '0;
    exp_b = '0;
    for (int k = 0; k < 16; k++) begin
      b = {32'hC000_0000 + 32'(k), 32'h0C00_0000 + 32'(k)};
      if (k < 8) exp_a[64*k +: 64] = b;
      else       exp_b[64*(k-8) +: 64] = b;
      send(b, (k == 7 || k == 15), cyc);
    end
    @(negedge clk);
    check_eq("t4_hold_s_tready", s_tready, 1'b0);
    check_eq("t4_m_tvalid", m_tvalid, 1'b1);
    check_eq("t4_m_tdata", m_tdata, exp_a);
    repeat (3) @(negedge clk);
    check_eq("t4_m_tdata_stable", m_tdata, exp_a);
    check_eq("t4_no_early_out", got_q.size(), 0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_frame("t4_frame_a", exp_a);
    check_frame("t4_frame_b", exp_b);
    check_eq("t4_no_dup", got_q.size(), 0);
    check_eq("t4_s_tready_back", s_tready, 1'b1);

    // Continuous 64 beats, one per cycle
    total = 0;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) begin
        b = {8'hD0, 8'(f), 8'(k), 8'h00, 32'(f * 8 + k)};
        send(b, (k == 7), cyc);
        total += cyc;
      end
    end
    check_eq("t5_cycles", total, 64);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5_frames", got_q.size(), 8);
    for (int f = 0; f < 8; f++) begin
      exp_a = '0;
      for (int k = 0; k < 8; k++) exp_a[64*k +: 64] = {8'hD0, 8'(f), 8'(k), 8'h00, 32'(f * 8 + k)};
      check_frame("t5_frame", exp_a);
    end

    // Reset mid-frame at slot 5
    for (int k = 0; k < 5; k++) send({32'hE000_0000 + 32'(k), 32'h1234_5678}, 1'b0, cyc);
    #3 rst = 1'b1;
    #1;
    check_idle("t6_rst_fill");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while in HOLD
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) send({32'hE100_0000 + 32'(k), 32'h8765_4321}, (k == 7 || k == 15), cyc);
    @(negedge clk);
    check_eq("t6_in_hold", s_tready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_idle("t6_rst_hold");
    @(negedge clk) rst = 1'b0;
    got_q.delete();
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    exp_a = '0;
    for (int k = 0; k < 8; k++) begin
      b = {32'hF000_0000 + 32'(k), 32'h0F00_0000 + 32'(k)};
      exp_a[64*k +: 64] = b;
      send(b, (k == 7), cyc);
    end
    repeat (2) @(posedge clk);
    #1;
    check_frame("t6_frame", exp_a);
    check_eq("t6_no_residue", got_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
